// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sharing the single-port program/data
// memory among instruction fetch (0), execute data access (1) and the
// loader/debug port (2). Each grant runs WAIT+1 memory cycles and ends with a
// one-cycle done pulse to the winner. Outputs decode from registers only.
module mem_bus_arbiter #(
    parameter int AW   = 8,
    parameter int DW   = 8,
    parameter int WAIT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    req,
    input  logic [2:0]    we,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [DW-1:0] wdata2,
    output logic [2:0]    done,
    output logic [DW-1:0] rdata,
    output logic [1:0]    grant_id,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    last_q,  last_d;
    logic [1:0]    gid_q,   gid_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q,    we_d;
    logic [3:0]    wcnt_q,  wcnt_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic [3:0]    req_ext;
    logic [1:0]    rr_first, rr_second, rr_third;
    logic          win_valid;
    logic [1:0]    win_id;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_we;

    // Round-robin pick: last+1, last+2, then last itself (mod 3).
    // rr_third equals last for legal pointer values; an illegal pointer
    // still yields a full 0,1,2 search.
    always_comb begin
        req_ext   = {1'b0, req};
        rr_first  = (last_q == 2'd0) ? 2'd1 : (last_q == 2'd1) ? 2'd2 : 2'd0;
        rr_second = (rr_first == 2'd0) ? 2'd1 : (rr_first == 2'd1) ? 2'd2 : 2'd0;
        rr_third  = (rr_second == 2'd0) ? 2'd1 : (rr_second == 2'd1) ? 2'd2 : 2'd0;
        win_valid = 1'b0;
        win_id    = rr_first;
        if (req_ext[rr_first]) begin
            win_valid = 1'b1;
            win_id    = rr_first;
        end else if (req_ext[rr_second]) begin
            win_valid = 1'b1;
            win_id    = rr_second;
        end else if (req_ext[rr_third]) begin
            win_valid = 1'b1;
            win_id    = rr_third;
        end
    end

    // Route the winning requester's address, data and write enable.
    always_comb begin
        sel_addr  = addr0;
        sel_wdata = wdata0;
        sel_we    = we[0];
        case (win_id)
            2'd1: begin
                sel_addr  = addr1;
                sel_wdata = wdata1;
                sel_we    = we[1];
            end
            2'd2: begin
                sel_addr  = addr2;
                sel_wdata = wdata2;
                sel_we    = we[2];
            end
            default: ;
        endcase
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gid_d   = gid_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        wcnt_d  = wcnt_q;
        rdata_d = rdata_q;
        done    = '0;
        busy    = 1'b0;
        mem_en  = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    gid_d   = win_id;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    we_d    = sel_we;
                    wcnt_d  = WAIT_CNT;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                busy   = 1'b1;
                mem_en = 1'b1;
                mem_we = we_q;
                if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    last_d  = gid_q;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                busy = 1'b1;
                case (gid_q)
                    2'd0:    done = 3'b001;
                    2'd1:    done = 3'b010;
                    2'd2:    done = 3'b100;
                    default: done = '0;
                endcase
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and access registers; async reset clears everything visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= 2'd2;
            gid_q   <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            wcnt_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            wcnt_q  <= wcnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign grant_id  = gid_q;
    assign rdata     = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Round-robin arbiter sharing the single-port program/data memory among three requesters: instruction fetch (port 0, active during Mif), execute-phase data access (port 1, active during Mex), and the program loader/debug port (port 2). It serialises accesses, inserts a programmable number of memory wait cycles, and returns a one-cycle `done` pulse per requester. The OR of `done[1:0]` drives the `done` input of `timing_generate`.

## Interface
- AW, 8, address width
- DW, 8, data width
- WAIT, 1, extra memory wait cycles per access (0..15); an access occupies WAIT+1 ACCESS cycles
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  3  per-requester access request, level
- we  in  3  per-requester write enable, qualified by req
- addr0, addr1, addr2  in  AW each  per-requester address
- wdata0, wdata1, wdata2  in  DW each  per-requester write data
- done  out  3  one-cycle completion pulse to the granted requester
- rdata  out  DW  read data, valid while `done` is high; holds until the next completion
- grant_id  out  2  index of the current or last granted requester
- busy  out  1  high in ACCESS and RESP
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid on the last ACCESS cycle

## Operation
- State machine IDLE -> ACCESS -> RESP -> IDLE. Encoding is free; unused encodings go to IDLE.
- **IDLE:** if any `req` bit is high, select a winner by round robin. Search order is last+1, last+2, last (mod 3). On the clock edge:
  - latch `grant_id`, the winner's address, write data and `we` into registers;
  - load `wcnt` = WAIT;
  - go to ACCESS.
  - With no request, stay in IDLE.
- **ACCESS:**
  - `mem_en` = 1; `mem_we` = latched we; `mem_addr`/`mem_wdata` come from the latched registers and are stable for the whole access.
  - If `wcnt` != 0, decrement it and stay.
  - If `wcnt` == 0, capture `mem_rdata` into `rdata` (read accesses only; `rdata` is unchanged on writes), update last := `grant_id`, and go to RESP.
- **RESP:** `done[grant_id]` = 1 for exactly one cycle; all other `done` bits are 0; `mem_en` = 0. Next state is IDLE.
- Requester rule: deassert `req` (or change it to a new request) at the edge that ends its `done` cycle. `req` still high in the following IDLE cycle is treated as a new request.
- `req` dropped mid-access: the access still completes and `done` still pulses. There is no abort.
- Inputs of non-granted requesters are ignored during ACCESS/RESP. Their requests stay pending while `req` remains high.
- Widths:
  - `wcnt` is 4 bits.
  - WAIT=0 gives a single ACCESS cycle.
  - The round-robin pointer wraps 2 -> 0.
- Reset values:
  - state = IDLE, last = 2 (requester 0 wins first);
  - `done` = 0, `rdata` = 0, `grant_id` = 0, `busy` = 0;
  - `mem_en` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- Reset mid-access: all outputs return to reset values asynchronously; no `done` is issued.

## Timing
- `req` sampled high in IDLE cycle c:
  - ACCESS occupies cycles c+1 .. c+1+WAIT;
  - `done` and `rdata` are valid in cycle c+2+WAIT.
  - Default WAIT=1 gives `done` 3 cycles after the request is sampled.
- Back-to-back throughput: one access per WAIT+3 cycles. IDLE always lasts at least one cycle between accesses.
- Simultaneous requests: exactly one grant per IDLE cycle, in round-robin order. No requester waits more than two other accesses.
- All outputs are registered or decoded from state only. There is no combinational path from `req` to `mem_*` or `done`.

## Test plan
- Reset with `req` = 3'b111 held high: first grant goes to 0, then 1, then 2, then 0. Each `done` is a single pulse; with WAIT=1, pulses are spaced 4 cycles apart.
- Single read: port 1 requests addr 8'h3C, memory model returns 8'hA5, WAIT=1 -> `mem_en` high for 2 cycles with `mem_addr`=3C; `done`=3'b010 and `rdata`=A5 in cycle c+3.
- Write from port 2: addr 8'h10, data 8'h5A -> `mem_we`=1, `mem_wdata`=5A for WAIT+1 cycles; `rdata` is unchanged from the previous read; `done`=3'b100.
- Port 0 changes `addr0` from 8'h01 to 8'hFF during ACCESS -> `mem_addr` stays 8'h01 through the access.
- WAIT=0 rebuild: port 0 read -> one ACCESS cycle, `done` in cycle c+2. Back-to-back requests from the same port complete every 3 cycles.
- `rst_n` pulsed low during the second ACCESS cycle -> `mem_en`, `busy` and `done` drop immediately. After release, no stale `done` pulse appears, and the next grant goes to port 0.
